branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Resolves X-stage control instructions: decides taken/not-taken, issues a
// registered PC redirect, and kills wrong-path instructions for SQUASH_CYCLES cycles.
//
// state  | meaning
// IDLE   | accepting control instructions from X
// SQUASH | redirect issued; wrong-path instructions killed until counter hits 0
module branch_resolve_unit #(
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             x_valid,
    input  logic [4:0]       x_opcode,
    input  logic [31:0]      x_pc,
    input  logic [16:0]      x_imm,
    input  logic [26:0]      x_target,
    input  logic [31:0]      x_rd_val,
    input  logic             neq,
    input  logic             lt,
    input  logic             rstatus_nz,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             squash,
    output logic [CNT_W-1:0] resolved_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_JAL = 5'b00011;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_BLT = 5'b00110;
    localparam logic [4:0] OP_BEX = 5'b10110;

    localparam logic [2:0] SQ_INIT = 3'(SQUASH_CYCLES - 1);

    typedef enum logic {IDLE, SQUASH} state_t;

    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;
    logic        redirect_q, redirect_next;

    logic        is_ctrl;
    logic        is_taken;
    logic [31:0] target;
    logic        accept;
    logic        take;

    always_comb begin
        is_ctrl  = 1'b0;
        is_taken = 1'b0;
        target   = 32'd0;
        case (x_opcode)
            OP_J, OP_JAL: begin
                is_ctrl  = 1'b1;
                is_taken = 1'b1;
                target   = {5'b0, x_target};
            end
            OP_JR: begin
                is_ctrl  = 1'b1;
                is_taken = 1'b1;
                target   = x_rd_val;
            end
            OP_BNE: begin
                is_ctrl  = 1'b1;
                is_taken = neq;
                target   = x_pc + 32'd1 + {{15{x_imm[16]}}, x_imm};
            end
            OP_BLT: begin
                is_ctrl  = 1'b1;
                is_taken = lt;
                target   = x_pc + 32'd1 + {{15{x_imm[16]}}, x_imm};
            end
            OP_BEX: begin
                is_ctrl  = 1'b1;
                is_taken = rstatus_nz;
                target   = {5'b0, x_target};
            end
            default: ;
        endcase
    end

    // Instructions seen during SQUASH are wrong-path and never accepted.
    assign accept = (state == IDLE) && x_valid && !stall && is_ctrl;
    assign take   = accept && is_taken;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            redirect_q <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            redirect_q <= redirect_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        redirect_next = redirect_q;
        if (!stall) begin
            redirect_next = 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        state_next    = SQUASH;
                        cnt_next      = SQ_INIT;
                        redirect_next = 1'b1;
                    end
                end
                SQUASH: begin
                    if (cnt == 3'd0) state_next = IDLE;
                    else             cnt_next   = cnt - 3'd1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        squash   = (state == SQUASH);
        redirect = redirect_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            redirect_pc  <= 32'd0;
            resolved_cnt <= '0;
            taken_cnt    <= '0;
        end else begin
            if (take) redirect_pc <= target;
            if (accept && (resolved_cnt != '1)) resolved_cnt <= resolved_cnt + CNT_W'(1);
            if (take && (taken_cnt != '1))      taken_cnt    <= taken_cnt + CNT_W'(1);
        end
    end

endmodule
